// File: rtl/io_arb_pkg.sv
// Shared state encoding, default widths and error data for the IO bus arbiter.
package io_arb_pkg;

  localparam int unsigned IO_ARB_ADDR_W = 32;
  localparam int unsigned IO_ARB_DATA_W = 32;
  localparam int unsigned IO_ARB_CNT_W  = 8;

  localparam logic [31:0] IO_ARB_ERR_DATA = 32'hFFFF_FFFF;

  // Encoding doubles as the one-hot grant vector (IDLE = no owner).
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY0 = 2'b01,
    BUSY1 = 2'b10
  } arb_state_e;

endpackage

// File: rtl/io_bus_arbiter_if.sv
// One single-cycle-select IO bus port: request side from a master, response side from a slave.
interface io_bus_arbiter_if #(
  parameter int unsigned ADDR_W = io_arb_pkg::IO_ARB_ADDR_W,
  parameter int unsigned DATA_W = io_arb_pkg::IO_ARB_DATA_W
);

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dat2;
  logic              sel;
  logic              we;
  logic [DATA_W-1:0] dat4;
  logic              ack;

  modport master (output addr, dat2, sel, we, input dat4, ack);
  modport slave  (input addr, dat2, sel, we, output dat4, ack);

endinterface

// File: rtl/io_arb_rr_pick.sv
// Combinational two-way round-robin picker; on a tie the master that was not last granted wins.
module io_arb_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);

  always_comb begin
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Round-robin two-master arbiter in front of the VGA device IO bus port.
// Define IO_ARB_TIMEOUT_EN to add the watchdog that retires transfers the slave never acks.
module io_bus_arbiter #(
  parameter int unsigned ADDR_W         = io_arb_pkg::IO_ARB_ADDR_W,
  parameter int unsigned DATA_W         = io_arb_pkg::IO_ARB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  io_bus_arbiter_if.slave  io_m0,
  io_bus_arbiter_if.slave  io_m1,
  io_bus_arbiter_if.master io_bus,
  output logic [1:0]       io_grant,
  output logic             io_timeout
);

  import io_arb_pkg::*;

  localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(IO_ARB_ERR_DATA);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;
  logic [1:0] pick;
  logic       wd_fire;

  io_arb_rr_pick u_pick (
    .req  ({io_m1.sel, io_m0.sel}),
    .last (last_q),
    .pick (pick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign io_grant = 2'(state_q);

`ifdef IO_ARB_TIMEOUT_EN
  localparam logic [IO_ARB_CNT_W-1:0] WD_LIMIT = IO_ARB_CNT_W'(TIMEOUT_CYCLES);

  logic [IO_ARB_CNT_W-1:0] wd_cnt_q;
  logic                    timeout_q;

  // A real ack in the same cycle takes precedence over the forced retire.
  assign wd_fire = ((state_q == BUSY0 && io_m0.sel) || (state_q == BUSY1 && io_m1.sel))
                   && !io_bus.ack && (wd_cnt_q == WD_LIMIT);

  // Counter is held at zero in IDLE, so every grant starts counting from 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wd_fire;
      wd_cnt_q  <= (state_q == IDLE) ? '0 : wd_cnt_q + IO_ARB_CNT_W'(1);
    end
  end

  assign io_timeout = timeout_q;
`else
  logic [IO_ARB_CNT_W-1:0] unused_timeout_cycles;

  assign unused_timeout_cycles = IO_ARB_CNT_W'(TIMEOUT_CYCLES);
  assign wd_fire               = 1'b0;
  assign io_timeout            = 1'b0;
`endif

  // Next state plus the combinational request/response steering for the current owner.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    io_bus.addr = ADDR_W'(0);
    io_bus.dat2 = DATA_W'(0);
    io_bus.sel  = 1'b0;
    io_bus.we   = 1'b0;
    io_m0.ack   = 1'b0;
    io_m0.dat4  = DATA_W'(0);
    io_m1.ack   = 1'b0;
    io_m1.dat4  = DATA_W'(0);

    case (state_q)
      IDLE: begin
        if (pick[0]) begin
          state_d = BUSY0;
        end else if (pick[1]) begin
          state_d = BUSY1;
        end
      end

      BUSY0: begin
        io_bus.addr = io_m0.addr;
        io_bus.dat2 = io_m0.dat2;
        io_bus.sel  = io_m0.sel;
        io_bus.we   = io_m0.we;
        io_m0.ack   = io_bus.ack | wd_fire;
        io_m0.dat4  = wd_fire ? ERR_DATA : io_bus.dat4;
        if (io_bus.ack || wd_fire || !io_m0.sel) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
      end

      BUSY1: begin
        io_bus.addr = io_m1.addr;
        io_bus.dat2 = io_m1.dat2;
        io_bus.sel  = io_m1.sel;
        io_bus.we   = io_m1.we;
        io_m1.ack   = io_bus.ack | wd_fire;
        io_m1.dat4  = wd_fire ? ERR_DATA : io_bus.dat4;
        if (io_bus.ack || wd_fire || !io_m1.sel) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: expected acks are queued by the stimulus and checked by a monitor.
module tb_io_bus_arbiter;

  localparam int unsigned TO_CYC = 4;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] grant;
  logic       timeout;

  always #5 clk = ~clk;

  io_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
  io_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
  io_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  io_bus_arbiter #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .io_m0      (m0_if.slave),
    .io_m1      (m1_if.slave),
    .io_bus     (bus_if.master),
    .io_grant   (grant),
    .io_timeout (timeout)
  );

  typedef struct {
    int          m;
    logic [31:0] dat;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned slave_lat   = 1;
  logic [31:0] slave_rdata = 32'h0;
  int unsigned sl_cnt      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
    #3;
  endtask

  task automatic push_exp(input int m, input logic [31:0] dat);
    exp_t e;
    e.m   = m;
    e.dat = dat;
    sb_q.push_back(e);
  endtask

  task automatic drive_m(input int m, input logic sel, input logic we,
                         input logic [31:0] addr, input logic [31:0] dat);
    if (m == 0) begin
      m0_if.sel = sel; m0_if.we = we; m0_if.addr = addr; m0_if.dat2 = dat;
    end else begin
      m1_if.sel = sel; m1_if.we = we; m1_if.addr = addr; m1_if.dat2 = dat;
    end
  endtask

  // Wait (bounded) for master m's ack, then drop its request after the next edge.
  task automatic wait_ack_drop(input int m, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      smp();
      seen = (m == 0) ? m0_if.ack : m1_if.ack;
    end
    chk($sformatf("ack_wait_m%0d", m), 32'(seen), 32'd1);
    tick();
    if (m == 0) m0_if.sel = 1'b0;
    else        m1_if.sel = 1'b0;
  endtask

  // Slave: acks once sel has been seen for slave_lat sampled cycles; slave_lat 0 never acks.
  initial begin
    bus_if.ack  = 1'b0;
    bus_if.dat4 = 32'h0;
    forever begin
      @(negedge clk);
      if (bus_if.sel) begin
        sl_cnt++;
        if (slave_lat != 0 && sl_cnt >= slave_lat) begin
          bus_if.ack  = 1'b1;
          bus_if.dat4 = slave_rdata;
        end
      end else begin
        sl_cnt      = 0;
        bus_if.ack  = 1'b0;
        bus_if.dat4 = 32'h0;
      end
    end
  end

  // Monitor: every master ack must match the oldest queued expectation.
  initial begin
    exp_t e;
    int   got_m;
    forever begin
      smp();
      if (m0_if.ack || m1_if.ack) begin
        got_m = m1_if.ack ? 1 : 0;
        chk("ack_onehot", 32'(m0_if.ack & m1_if.ack), 32'd0);
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack: m%0d acked, required no ack (t=%0t)", got_m, $time);
        end else begin
          e = sb_q.pop_front();
          chk("ack_master", 32'(got_m), 32'(e.m));
          chk("ack_dat4", got_m == 1 ? m1_if.dat4 : m0_if.dat4, e.dat);
          chk("other_dat4", got_m == 1 ? m0_if.dat4 : m1_if.dat4, 32'h0);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "bench time limit");
  end

  initial begin : main
    logic [1:0] exp_gr[8];
    int         ack_idx, to_idx, to_cnt, held;
    logic       drop_pending;

    exp_gr[0] = 2'b01; exp_gr[1] = 2'b00; exp_gr[2] = 2'b10; exp_gr[3] = 2'b00;
    exp_gr[4] = 2'b01; exp_gr[5] = 2'b00; exp_gr[6] = 2'b10; exp_gr[7] = 2'b00;

    // Reset values, with master 0 requesting to prove IDLE zeroes the slave side.
    drive_m(0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drive_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    smp();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_bus_sel", 32'(bus_if.sel), 32'd0);
    chk("rst_bus_we", 32'(bus_if.we), 32'd0);
    chk("rst_bus_addr", bus_if.addr, 32'h0);
    chk("rst_bus_dat2", bus_if.dat2, 32'h0);
    chk("rst_m0_ack", 32'(m0_if.ack), 32'd0);
    chk("rst_m0_dat4", m0_if.dat4, 32'h0);
    drive_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    reset = 1'b0;

    // Single write from master 0, slave acks on the third selected cycle.
    slave_lat   = 3;
    slave_rdata = 32'hCAFE_0001;
    push_exp(0, 32'hCAFE_0001);
    tick();
    drive_m(0, 1'b1, 1'b1, 32'h10, 32'hABCD);
    smp();
    chk("t1_grant_pre", 32'(grant), 32'd0);
    smp();
    chk("t1_grant", 32'(grant), 32'd1);
    chk("t1_bus_addr", bus_if.addr, 32'h10);
    chk("t1_bus_dat2", bus_if.dat2, 32'hABCD);
    chk("t1_bus_we", 32'(bus_if.we), 32'd1);
    chk("t1_bus_sel", 32'(bus_if.sel), 32'd1);
    wait_ack_drop(0, 10);
    smp();
    chk("t1_idle_grant", 32'(grant), 32'd0);
    chk("t1_idle_sel", 32'(bus_if.sel), 32'd0);

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Continuous contention, single-cycle slave: grants alternate with an IDLE gap.
    slave_lat   = 1;
    slave_rdata = 32'hC0DE_0002;
    push_exp(0, 32'hC0DE_0002);
    push_exp(1, 32'hC0DE_0002);
    push_exp(0, 32'hC0DE_0002);
    push_exp(1, 32'hC0DE_0002);
    tick();
    drive_m(0, 1'b1, 1'b0, 32'h100, 32'h0);
    drive_m(1, 1'b1, 1'b0, 32'h200, 32'h0);
    smp();
    for (int i = 0; i < 8; i++) begin
      smp();
      chk($sformatf("t2_grant_%0d", i), 32'(grant), 32'(exp_gr[i]));
    end
    m0_if.sel = 1'b0;
    m1_if.sel = 1'b0;
    smp();
    chk("t2_end_grant", 32'(grant), 32'd0);

    // Master 1 read: data routed to master 1 only.
    slave_lat   = 2;
    slave_rdata = 32'h1234_5678;
    push_exp(1, 32'h1234_5678);
    tick();
    drive_m(1, 1'b1, 1'b0, 32'h20, 32'h0);
    wait_ack_drop(1, 10);
    smp();
    chk("t3_idle_grant", 32'(grant), 32'd0);

    // Master 0 aborts two cycles into its grant; pending master 1 follows.
    slave_lat = 0;
    tick();
    drive_m(0, 1'b1, 1'b1, 32'h30, 32'h3333);
    drive_m(1, 1'b1, 1'b0, 32'h40, 32'h0);
    smp();
    smp();
    chk("t4_grant_a", 32'(grant), 32'd1);
    smp();
    chk("t4_grant_b", 32'(grant), 32'd1);
    tick();
    m0_if.sel = 1'b0;
    smp();
    chk("t4_abort_bus_sel", 32'(bus_if.sel), 32'd0);
    smp();
    chk("t4_abort_idle", 32'(grant), 32'd0);
    smp();
    chk("t4_next_grant", 32'(grant), 32'd2);
    chk("t4_bus_addr", bus_if.addr, 32'h40);
    slave_rdata = 32'h0BAD_F00D;
    push_exp(1, 32'h0BAD_F00D);
    slave_lat = 1;
    wait_ack_drop(1, 10);
    smp();
    chk("t4_end_grant", 32'(grant), 32'd0);

    // Slave never acks.
    slave_lat = 0;
    tick();
    drive_m(0, 1'b1, 1'b0, 32'h50, 32'h0);
`ifdef IO_ARB_TIMEOUT_EN
    push_exp(0, 32'hFFFF_FFFF);
    ack_idx      = -1;
    to_idx       = -1;
    to_cnt       = 0;
    drop_pending = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (drop_pending) begin
        m0_if.sel    = 1'b0;
        drop_pending = 1'b0;
      end
      smp();
      if (m0_if.ack && ack_idx < 0) begin
        ack_idx      = i;
        drop_pending = 1'b1;
      end
      if (timeout) begin
        to_cnt++;
        if (to_idx < 0) to_idx = i;
      end
      if (i == 5) chk("t5_idle_after_retire", 32'(grant), 32'd0);
    end
    chk("t5_ack_cycle", 32'(ack_idx), 32'(TO_CYC));
    chk("t5_timeout_pulses", 32'(to_cnt), 32'd1);
    chk("t5_timeout_cycle", 32'(to_idx), 32'(TO_CYC + 1));
`else
    held = 0;
    smp();
    for (int i = 0; i < 1000; i++) begin
      smp();
      if (grant == 2'b01 && !m0_if.ack && !timeout) held++;
    end
    chk("t5_grant_held", 32'(held), 32'd1000);
    tick();
    m0_if.sel = 1'b0;
    smp();
    smp();
    chk("t5_abort_idle", 32'(grant), 32'd0);
`endif

    // Reset in the middle of a master 1 grant.
    slave_lat = 0;
    tick();
    drive_m(1, 1'b1, 1'b0, 32'h60, 32'h0);
    smp();
    smp();
    chk("t6_grant_busy1", 32'(grant), 32'd2);
    chk("t6_bus_sel_busy", 32'(bus_if.sel), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_async_bus_sel", 32'(bus_if.sel), 32'd0);
    chk("t6_async_grant", 32'(grant), 32'd0);
    chk("t6_async_m1_ack", 32'(m1_if.ack), 32'd0);
    drive_m(0, 1'b1, 1'b0, 32'h70, 32'h0);
    slave_lat   = 1;
    slave_rdata = 32'h600D_0006;
    push_exp(0, 32'h600D_0006);
    push_exp(1, 32'h600D_0006);
    tick();
    tick();
    reset = 1'b0;
    smp();
    chk("t6_post_rst_idle", 32'(grant), 32'd0);
    smp();
    chk("t6_first_grant", 32'(grant), 32'd1);
    tick();
    m0_if.sel = 1'b0;
    wait_ack_drop(1, 10);

    repeat (3) smp();
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    chk("final_grant", 32'(grant), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_bus_arbiter.md
# io_bus_arbiter

Two-master, one-slave arbiter for the single-cycle-select IO bus in front of `WB_VGA_Dev`. It shares the VGA device's bus port between the CPU (master 0) and the framebuffer DMA/blitter (master 1). Grants are round-robin, each grant is held for a whole transfer until `ack`, and an optional watchdog retires stuck transfers. It sits between the CPU IO decode and the VGA device's `io_bus_*` port.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT_CYCLES`, 255, cycles in a grant without `ack` before forced retire (watchdog builds only); range 1..255
- `clk` in 1 — single system clock
- `reset` in 1 — asynchronous, active-high
- `io_m0_addr`, `io_m1_addr` in ADDR_W — master address
- `io_m0_dat2`, `io_m1_dat2` in DATA_W — master write data
- `io_m0_sel`, `io_m1_sel` in 1 — request, held high until `ack`
- `io_m0_we`, `io_m1_we` in 1 — write enable
- `io_m0_dat4`, `io_m1_dat4` out DATA_W — read data to master
- `io_m0_ack`, `io_m1_ack` out 1 — transfer complete
- `io_bus_addr`, `io_bus_dat2`, `io_bus_sel`, `io_bus_we` out — to slave
- `io_bus_dat4` in DATA_W, `io_bus_ack` in 1 — from slave
- `io_grant` out 2 — one-hot current owner; 00 when idle
- `io_timeout` out 1 — one-cycle pulse on forced retire

## Operation
- States:
  - IDLE: no owner.
  - BUSY0: master 0 owns the slave.
  - BUSY1: master 1 owns the slave.
- Priority pointer `last`: the master granted most recently. It resets to 1, so master 0 wins the first tie.
- IDLE:
  - Exactly one `sel` high → go to that master's BUSY.
  - Both high → go to BUSY of the master that is not `last`.
- BUSYx:
  - Slave outputs are a combinational mux of master x's `addr`/`dat2`/`we`/`sel`.
  - `io_bus_ack` and `io_bus_dat4` are routed combinationally to master x only.
  - The other master sees `ack`=0 and `dat4`=0.
- BUSYx + `io_bus_ack` → IDLE on the next edge, and `last` ← x.
- BUSYx + master x drops `sel` without `ack` (abort) → IDLE. `last` ← x.
- In IDLE, all slave outputs are 0: `sel`, `we`, `addr`, `dat2`.
- Watchdog:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle without `ack`.
  - When the counter equals `TIMEOUT_CYCLES`, the arbiter drives `ack`=1 and `dat4`=32'hFFFF_FFFF to master x for that cycle, pulses `io_timeout`, and goes to IDLE with `last` ← x.
  - If a real `ack` arrives in the same cycle, the real ack wins and there is no timeout pulse.
- Reset mid-transfer: the arbiter drops to IDLE immediately and asynchronously. The slave `sel` falls with it, and the master's transfer is lost.

## Timing
- Reset values:
  - State IDLE, `last`=1, counter 0.
  - `io_grant`=00, `io_timeout`=0.
  - All `io_bus_*` outputs 0; all master `ack`/`dat4` 0.
- A `sel` rising at edge N is sampled at edge N+1. The arbiter enters BUSY and asserts slave `sel` from N+1.
- A master's `ack` has the same cycle timing as the slave's `ack`; there is no added latency on the return path.
- After each `ack` there is one mandatory IDLE cycle. A back-to-back transfer therefore costs the slave latency plus 2 cycles.
- Under continuous contention, grants strictly alternate 0,1,0,1…
- `io_grant` is registered and equals the state encoding.

## Configuration
- `IO_ARB_TIMEOUT_EN`:
  - Defined: watchdog counter, forced retire and `io_timeout` are present.
  - Undefined: no counter; BUSY waits indefinitely for `ack` or abort; `io_timeout` is tied to 0; `TIMEOUT_CYCLES` is ignored.

## Structure
- Package `io_arb_pkg` holds:
  - the state enum (IDLE, BUSY0, BUSY1)
  - `IO_ARB_ERR_DATA` = 32'hFFFF_FFFF
  - the default widths
- Sub-module `io_arb_rr_pick`: a combinational 2-way round-robin picker.
  - Inputs: `req[1:0]`, `last`.
  - Output: one-hot `pick`.

## Test plan
- After reset release, `io_m0_sel`=1, write addr 32'h10, dat 32'hABCD, slave acks 3 cycles later → `io_grant`=01 one cycle after `sel`; slave sees addr 32'h10 / dat 32'hABCD / `we`=1; `io_m0_ack` pulses; `io_m1_ack` stays 0.
- Both masters request continuously, slave acks every cycle it is selected → grants go 01,00,10,00,01…; master 0 is served first.
- Master 1 reads, slave returns 32'h1234_5678 → `io_m1_dat4`=32'h1234_5678 in the ack cycle; `io_m0_dat4`=0.
- Master 0 drops `sel` 2 cycles into the grant with no ack → IDLE next cycle; a pending master 1 is granted next.
- With `IO_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4, slave never acks → `io_timeout` pulses once, master gets `ack` with `dat4`=32'hFFFF_FFFF, state returns to IDLE. Without the macro → grant is held for 1000 cycles.
- Reset asserted mid-BUSY1 → `io_bus_sel`, `io_grant` and `io_m1_ack` are 0 asynchronously; the first grant after reset goes to master 0.
